mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 80 ++++++++
 tb/tb_mem_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: splits 1/2/4-byte requests into byte-serial memory commands,
// assembling little-endian read data and reporting completion with a one-cycle pulse.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 17,
   parameter int LEN = 32,
   parameter int BYTE_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_type,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [LEN-1:0]        req_wdata,
   output logic                  resp_valid,
   output logic [LEN-1:0]        resp_rdata,
   output logic [1:0]            mem_vis_signal,
   output logic [ADDR_WIDTH-1:0] mem_vis_addr,
   output logic [BYTE_SIZE-1:0]  writen_data,
   input  logic [BYTE_SIZE-1:0]  mem_data
);
   localparam logic [1:0] T_IDLE = 2'b00, T_WRITE = 2'b11;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t state, state_nx;
   logic [1:0] typ, last;
   logic [2:0] cnt;
   logic [LEN-1:0] wsh, rdata;
   logic accept;
   assign req_ready = state == IDLE;
   assign resp_valid = state == DONE;
   assign resp_rdata = rdata;
   assign accept = req_valid && req_ready && req_type != T_IDLE;
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (accept ? (req_type == T_WRITE ? WRITE : READ) : IDLE) :
                 state == WRITE ? (cnt == {1'b0, last} ? DONE : WRITE) :
                 state == READ ? (cnt == {1'b0, last} + 3'd1 ? DONE : READ) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // cnt is the index of the command presented this cycle; reads capture byte cnt-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         typ <= T_IDLE;
         last <= 2'd0;
         cnt <= 3'd0;
         wsh <= '0;
         rdata <= '0;
         mem_vis_signal <= T_IDLE;
         mem_vis_addr <= '0;
         writen_data <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            typ <= req_type;
            last <= req_size == 2'b00 ? 2'd0 : req_size == 2'b01 ? 2'd1 : 2'd3;
            cnt <= 3'd0;
            wsh <= req_wdata;
            rdata <= '0;
            mem_vis_signal <= req_type;
            mem_vis_addr <= req_addr;
            writen_data <= req_wdata[BYTE_SIZE-1:0];
         end
      end else if (state == WRITE) begin
         if (cnt == {1'b0, last}) mem_vis_signal <= T_IDLE;
         else begin
            cnt <= cnt + 3'd1;
            mem_vis_addr <= mem_vis_addr + 1'b1;
            wsh <= wsh >> BYTE_SIZE;
            writen_data <= wsh[2*BYTE_SIZE-1:BYTE_SIZE];
         end
      end else if (state == READ) begin
         cnt <= cnt + 3'd1;
         if (cnt != 3'd0) rdata[int'(cnt - 3'd1)*BYTE_SIZE +: BYTE_SIZE] <= mem_data;
         mem_vis_signal <= cnt < {1'b0, last} ? typ : T_IDLE;
         if (cnt < {1'b0, last}) mem_vis_addr <= mem_vis_addr + 1'b1;
      end else mem_vis_signal <= T_IDLE;
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl with a byte-array memory
// and a transaction-level reference model of expected commands and responses.
module tb_mem_ctrl;
   logic clk = 0, rst_n = 1, req_valid = 0;
   logic [1:0] req_type = 0, req_size = 0;
   logic [16:0] req_addr = 0;
   logic [31:0] req_wdata = 0;
   logic req_ready, resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0] mem_vis_signal;
   logic [16:0] mem_vis_addr;
   logic [7:0] writen_data, mem_data;

   mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_vis_signal(mem_vis_signal),
      .mem_vis_addr(mem_vis_addr), .writen_data(writen_data), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:131071];
   logic [7:0] ref_mem [0:131071];
   int cyc = 0;
   int checks = 0, failures = 0;
   int busy_until = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      mem_data <= mem[mem_vis_addr];
      if (mem_vis_signal == 2'b11) mem[mem_vis_addr] = writen_data;
   end

   typedef struct {int cyc; logic [1:0] sig; logic [16:0] addr; logic [7:0] data;} cmd_t;
   typedef struct {int cyc; logic [31:0] rdata;} resp_t;
   cmd_t cmd_q[$];
   resp_t resp_q[$];
   cmd_t mc;
   resp_t mr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) if (rst_n) begin
      chk("req_ready", req_ready, cyc > busy_until);
      if (mem_vis_signal != 2'b00) begin
         if (cmd_q.size() == 0) chk("unexpected_cmd", mem_vis_signal, 0);
         else begin
            mc = cmd_q.pop_front();
            chk("cmd_cycle", cyc, mc.cyc);
            chk("cmd_sig", mem_vis_signal, mc.sig);
            chk("cmd_addr", mem_vis_addr, mc.addr);
            if (mc.sig == 2'b11) chk("cmd_wdata", writen_data, mc.data);
         end
      end else if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
         chk("missing_cmd", mem_vis_signal, cmd_q[0].sig);
         void'(cmd_q.pop_front());
      end
      if (resp_valid) begin
         if (resp_q.size() == 0) chk("unexpected_resp", resp_valid, 0);
         else begin
            mr = resp_q.pop_front();
            chk("resp_cycle", cyc, mr.cyc);
            chk("resp_rdata", resp_rdata, mr.rdata);
         end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
         chk("missing_resp", resp_valid, 1);
         void'(resp_q.pop_front());
      end
   end

   task automatic issue(input logic [1:0] t, input logic [16:0] a, input logic [1:0] s,
                        input logic [31:0] w, input bit keep);
      int n, lat, k;
      logic [31:0] exp;
      logic [16:0] ai;
      req_valid = 1; req_type = t; req_addr = a; req_size = s; req_wdata = w;
      k = 0;
      while (!req_ready && k < 50) begin @(negedge clk); #1; k++; end
      if (!req_ready) begin
         chk("accept_timeout", req_ready, 1);
         req_valid = 0;
         return;
      end
      n = s == 0 ? 1 : s == 1 ? 2 : 4;
      lat = t == 2'b11 ? n + 1 : n + 2;
      exp = 0;
      for (int i = 0; i < n; i++) begin
         ai = a + 17'(i);
         cmd_q.push_back('{cyc + 1 + i, t, ai, w[8*i +: 8]});
         if (t == 2'b11) ref_mem[ai] = w[8*i +: 8];
         else exp |= 32'(ref_mem[ai]) << (8 * i);
      end
      resp_q.push_back('{cyc + lat, exp});
      busy_until = cyc + lat;
      @(negedge clk); #1;
      if (!keep) req_valid = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && (cmd_q.size() != 0 || resp_q.size() != 0); k++) begin
         @(negedge clk); #1;
      end
      chk("drain_cmd", cmd_q.size(), 0);
      chk("drain_resp", resp_q.size(), 0);
   endtask

   task automatic chk_reset();
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_sig", mem_vis_signal, 0);
      chk("rst_addr", mem_vis_addr, 0);
      chk("rst_wdata", writen_data, 0);
   endtask

   initial begin
      logic [16:0] a;
      logic [7:0] keep2, keep3;
      for (int i = 0; i < 131072; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[17'h10] = 8'h11; mem[17'h11] = 8'h22; mem[17'h12] = 8'h33; mem[17'h13] = 8'h44;
      mem[17'h1FFFF] = 8'hAB; mem[17'h0] = 8'hCD;
      ref_mem[17'h10] = 8'h11; ref_mem[17'h11] = 8'h22; ref_mem[17'h12] = 8'h33; ref_mem[17'h13] = 8'h44;
      ref_mem[17'h1FFFF] = 8'hAB; ref_mem[17'h0] = 8'hCD;
      #1 rst_n = 0;
      #1 chk_reset();
      @(negedge clk); #1 rst_n = 1;
      issue(2'b10, 17'h10, 2'b10, 0, 0); drain();
      issue(2'b11, 17'h100, 2'b00, 32'hDEADBEEF, 0); drain();
      issue(2'b10, 17'h100, 2'b00, 0, 0); drain();
      issue(2'b01, 17'h1FFFF, 2'b01, 0, 0); drain();
      issue(2'b10, 17'h10, 2'b11, 0, 0); drain();
      issue(2'b11, 17'h300, 2'b10, 32'h01020304, 1);
      issue(2'b11, 17'h304, 2'b10, 32'hA0B0C0D0, 0); drain();
      issue(2'b10, 17'h300, 2'b10, 0, 0); drain();
      for (int i = 0; i < 40; i++)
         issue(2'($urandom_range(1, 3)), 17'h1FFF0 + 17'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), $urandom, i < 39 ? 1'($urandom_range(0, 1)) : 1'b0);
      drain();
      a = 17'h200;
      keep2 = ref_mem[a + 17'd2];
      keep3 = ref_mem[a + 17'd3];
      issue(2'b11, a, 2'b10, 32'h55667788, 0);
      @(posedge clk);
      @(posedge clk); #1 rst_n = 0;
      cmd_q.delete(); resp_q.delete();
      ref_mem[a + 17'd2] = keep2;
      ref_mem[a + 17'd3] = keep3;
      #1 chk_reset();
      busy_until = 0;
      @(negedge clk); #1 rst_n = 1;
      for (int i = 0; i < 4; i++) chk("abort_mem", mem[a + 17'(i)], ref_mem[a + 17'(i)]);
      issue(2'b10, a, 2'b10, 0, 0); drain();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
